// File: rtl/axis_tx_packetizer_if.sv
// rtl/axis_tx_packetizer_if.sv - block-input and AXI4-Stream output bundle of axis_tx_packetizer
interface axis_tx_packetizer_if;
  logic         encryp_decryp;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_key;
  logic [63:0]  in_nonce;
  logic [63:0]  in_counter;
  logic [511:0] in_data;
  logic         m_axis_ready;
  logic         m_axis_valid;
  logic [31:0]  m_axis_data;
  logic         m_axis_last;
  logic         busy;

  // Packetizer side: consumes blocks, drives the stream.
  modport slave (
    input  encryp_decryp, in_valid, in_key, in_nonce, in_counter, in_data, m_axis_ready,
    output in_ready, m_axis_valid, m_axis_data, m_axis_last, busy
  );

  // Environment side: offers blocks, sinks the stream.
  modport master (
    output encryp_decryp, in_valid, in_key, in_nonce, in_counter, in_data, m_axis_ready,
    input  in_ready, m_axis_valid, m_axis_data, m_axis_last, busy
  );
endinterface

// File: rtl/axis_tx_packetizer.sv
// rtl/axis_tx_packetizer.sv - serializes a ChaCha block (+ optional key/nonce/counter header) onto 32-bit AXI4-Stream
// Define AXIS_TX_PACKETIZER_PREFETCH_EN for a one-deep staging register and zero-gap packets.
module axis_tx_packetizer (
  input  logic                axis_clk,
  input  logic                axis_reset_n,
  axis_tx_packetizer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t       state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic         mode_q;
  logic [255:0] key_q;
  logic [63:0]  nonce_q;
  logic [63:0]  counter_q;
  logic [511:0] data_q;

  logic         accept;
  logic         beat;
  logic         is_last;
  logic         ld_in;
  logic [3:0]   hidx;
  logic [3:0]   didx;
  logic [511:0] hdr_w;
  logic [31:0]  hdr_word;
  logic [31:0]  data_word;

`ifdef AXIS_TX_PACKETIZER_PREFETCH_EN
  logic         stg_full_q;
  logic         stg_mode_q;
  logic [255:0] stg_key_q;
  logic [63:0]  stg_nonce_q;
  logic [63:0]  stg_counter_q;
  logic [511:0] stg_data_q;
  logic         ld_stg;
  logic         stg_wr;

  assign bus.in_ready = axis_reset_n & ~stg_full_q;
`else
  assign bus.in_ready = axis_reset_n & (state_q == IDLE);
`endif

  assign accept = bus.in_valid & bus.in_ready;
  assign beat   = bus.m_axis_valid & bus.m_axis_ready;

  // Header padded to 512 bits so both selects share one 4-bit word index.
  assign hdr_w     = {key_q, nonce_q, counter_q, 128'd0};
  assign hidx      = idx_q[3:0];
  assign didx      = mode_q ? idx_q[3:0] : (idx_q[3:0] - 4'd12);
  assign hdr_word  = hdr_w[{4'd15 - hidx, 5'd0} +: 32];
  assign data_word = data_q[{4'd15 - didx, 5'd0} +: 32];
  assign is_last   = (state_q == DATA) && (didx == 4'd15);

  assign bus.m_axis_valid = (state_q != IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.m_axis_last  = is_last;
  assign bus.m_axis_data  = (state_q == HDR)  ? hdr_word  :
                            (state_q == DATA) ? data_word : 32'd0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ld_in   = 1'b0;
`ifdef AXIS_TX_PACKETIZER_PREFETCH_EN
    ld_stg  = 1'b0;
    stg_wr  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          ld_in   = 1'b1;
          idx_d   = 5'd0;
          state_d = bus.encryp_decryp ? DATA : HDR;
        end
      end
      HDR: begin
        if (beat) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd11) state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          if (is_last) begin
            idx_d   = 5'd0;
            state_d = IDLE;
`ifdef AXIS_TX_PACKETIZER_PREFETCH_EN
            if (stg_full_q) begin
              ld_stg  = 1'b1;
              state_d = stg_mode_q ? DATA : HDR;
            end else if (accept) begin
              ld_in   = 1'b1;
              state_d = bus.encryp_decryp ? DATA : HDR;
            end
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXIS_TX_PACKETIZER_PREFETCH_EN
    // Blocks accepted while a packet is streaming wait in staging.
    stg_wr = accept & ~ld_in;
`endif
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_reset_n) begin
      state_q   <= IDLE;
      idx_q     <= 5'd0;
      mode_q    <= 1'b0;
      key_q     <= '0;
      nonce_q   <= '0;
      counter_q <= '0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (ld_in) begin
        mode_q    <= bus.encryp_decryp;
        key_q     <= bus.in_key;
        nonce_q   <= bus.in_nonce;
        counter_q <= bus.in_counter;
        data_q    <= bus.in_data;
      end
`ifdef AXIS_TX_PACKETIZER_PREFETCH_EN
      else if (ld_stg) begin
        mode_q    <= stg_mode_q;
        key_q     <= stg_key_q;
        nonce_q   <= stg_nonce_q;
        counter_q <= stg_counter_q;
        data_q    <= stg_data_q;
      end
`endif
    end
  end

`ifdef AXIS_TX_PACKETIZER_PREFETCH_EN
  always_ff @(posedge axis_clk) begin
    if (!axis_reset_n) begin
      stg_full_q    <= 1'b0;
      stg_mode_q    <= 1'b0;
      stg_key_q     <= '0;
      stg_nonce_q   <= '0;
      stg_counter_q <= '0;
      stg_data_q    <= '0;
    end else if (stg_wr) begin
      stg_full_q    <= 1'b1;
      stg_mode_q    <= bus.encryp_decryp;
      stg_key_q     <= bus.in_key;
      stg_nonce_q   <= bus.in_nonce;
      stg_counter_q <= bus.in_counter;
      stg_data_q    <= bus.in_data;
    end else if (ld_stg) begin
      stg_full_q    <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_axis_tx_packetizer.sv
// tb/tb_axis_tx_packetizer.sv - self-checking bench for axis_tx_packetizer
module tb_axis_tx_packetizer;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  axis_tx_packetizer_if bus ();

  axis_tx_packetizer dut (
    .axis_clk     (clk),
    .axis_reset_n (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [255:0] key;
    logic [63:0]  nonce;
    logic [63:0]  ctr;
    logic [511:0] data;
    int           pat;
    int           exp_beats;
    logic [31:0]  exp_first;
    logic [31:0]  exp_last;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom)};
    return r;
  endfunction

  function automatic vec_t make_vec(input logic m, input logic [255:0] k, input logic [63:0] n,
                                    input logic [63:0] c, input logic [511:0] d, input int p);
    vec_t v;
    v.mode = m; v.key = k; v.nonce = n; v.ctr = c; v.data = d; v.pat = p;
    v.exp_beats = m ? 16 : 28;
    v.exp_first = m ? d[511:480] : k[255:224];
    v.exp_last  = d[31:0];
    return v;
  endfunction

  // Reference word stream: header (encryption only) then the 16 data words, MSB word first.
  task automatic build_expected(input vec_t v);
    exp_q.delete();
    if (v.mode == 1'b0) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(32'(v.key >> (32 * i)));
      exp_q.push_back(v.nonce[63:32]);
      exp_q.push_back(v.nonce[31:0]);
      exp_q.push_back(v.ctr[63:32]);
      exp_q.push_back(v.ctr[31:0]);
    end
    for (int i = 15; i >= 0; i--) exp_q.push_back(32'(v.data >> (32 * i)));
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    check("accept_wait", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic send_and_check(input vec_t v, input string tag);
    bit          ok;
    bit          prev_stall;
    logic        rdy;
    logic [31:0] prev_d;
    logic        prev_l;
    logic [31:0] first_w;
    logic [31:0] last_w;
    int          beats;
    int          cyc;
    build_expected(v);
    bus.encryp_decryp = v.mode;
    bus.in_key        = v.key;
    bus.in_nonce      = v.nonce;
    bus.in_counter    = v.ctr;
    bus.in_data       = v.data;
    bus.in_valid      = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid      = 1'b0;
    bus.encryp_decryp = ~v.mode;
    bus.in_key        = rnd256();
    bus.in_nonce      = {$urandom, $urandom};
    bus.in_counter    = {$urandom, $urandom};
    bus.in_data       = rnd512();
    check({tag, "_first_valid"}, {63'd0, bus.m_axis_valid}, 64'd1);
    beats = 0; cyc = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;
    first_w = '0; last_w = '0;
    while (beats < exp_q.size() && cyc < 500) begin
      case (v.pat)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 3) == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.m_axis_ready = rdy;
      #1;
      check({tag, "_valid_hold"}, {63'd0, bus.m_axis_valid}, 64'd1);
      if (!bus.m_axis_valid) break;
      if (prev_stall) begin
        check({tag, "_stall_data"}, bus.m_axis_data, prev_d);
        check({tag, "_stall_last"}, {63'd0, bus.m_axis_last}, {63'd0, prev_l});
      end
      if (rdy) begin
        check($sformatf("%s_word%0d", tag, beats), bus.m_axis_data, exp_q[beats]);
        check($sformatf("%s_last%0d", tag, beats), {63'd0, bus.m_axis_last},
              {63'd0, (beats == exp_q.size() - 1)});
        if (beats == 0) first_w = bus.m_axis_data;
        last_w = bus.m_axis_data;
        beats++;
      end
      prev_stall = !rdy;
      prev_d     = bus.m_axis_data;
      prev_l     = bus.m_axis_last;
      @(negedge clk);
      cyc++;
    end
    bus.m_axis_ready = 1'b1;
    check({tag, "_beats"}, 64'(beats), 64'(v.exp_beats));
    check({tag, "_first_word"}, first_w, v.exp_first);
    check({tag, "_last_word"}, last_w, v.exp_last);
    check({tag, "_idle_valid"}, {63'd0, bus.m_axis_valid}, 64'd0);
    check({tag, "_idle_busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic back_to_back(input vec_t a, input vec_t b);
    bit          ok;
    bit          b_acc;
    logic        vtr[48];
    logic        ltr[48];
    logic        rtr[48];
    logic [31:0] dtr[48];
    int          off;
    bus.m_axis_ready  = 1'b1;
    bus.encryp_decryp = a.mode; bus.in_key = a.key; bus.in_nonce = a.nonce;
    bus.in_counter    = a.ctr;  bus.in_data = a.data; bus.in_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.encryp_decryp = b.mode; bus.in_key = b.key; bus.in_nonce = b.nonce;
    bus.in_counter    = b.ctr;  bus.in_data = b.data;
    b_acc = 0;
    for (int i = 0; i < 48; i++) begin
      vtr[i] = bus.m_axis_valid; ltr[i] = bus.m_axis_last;
      rtr[i] = bus.in_ready;     dtr[i] = bus.m_axis_data;
      if (bus.in_valid && bus.in_ready) b_acc = 1;
      @(negedge clk);
      if (b_acc) bus.in_valid = 1'b0;
    end
    check("b2b_a_last", {63'd0, ltr[15]}, 64'd1);
    check("b2b_a_word15", dtr[15], a.data[31:0]);
`ifdef AXIS_TX_PACKETIZER_PREFETCH_EN
    off = 16;
    check("b2b_stage_full_ready1", {63'd0, rtr[1]}, 64'd0);
    check("b2b_stage_full_ready15", {63'd0, rtr[15]}, 64'd0);
`else
    off = 17;
    check("b2b_gap_valid", {63'd0, vtr[16]}, 64'd0);
    check("b2b_busy_ready", {63'd0, rtr[5]}, 64'd0);
`endif
    build_expected(b);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("b2b_b_valid%0d", j), {63'd0, vtr[off + j]}, 64'd1);
      check($sformatf("b2b_b_word%0d", j), dtr[off + j], exp_q[j]);
    end
    check("b2b_b_last", {63'd0, ltr[off + 15]}, 64'd1);
    check("b2b_after_valid", {63'd0, vtr[off + 16]}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] skey;
    logic [511:0] sdata;
    logic [31:0]  w5;
    bit           ok;
    tests = 0;
    fails = 0;
    skey  = '0;
    sdata = '0;
    for (int i = 1; i <= 8; i++) skey = {skey[223:0], 32'(i)};
    for (int i = 0; i < 16; i++) sdata = {sdata[479:0], 32'(32'h100 + i)};

    vecs[0] = make_vec(1'b0, skey, 64'hA0A0A0A0_B1B1B1B1, 64'd5, sdata, 0);
    vecs[1] = make_vec(1'b1, skey, 64'hA0A0A0A0_B1B1B1B1, 64'd5, sdata, 0);
    vecs[2] = make_vec(1'b0, skey, 64'hA0A0A0A0_B1B1B1B1, 64'd5, sdata, 1);
    vecs[3] = make_vec(1'b0, rnd256(), {$urandom, $urandom}, {$urandom, $urandom}, rnd512(), 2);
    vecs[4] = make_vec(1'b1, rnd256(), {$urandom, $urandom}, {$urandom, $urandom}, rnd512(), 2);
    vecs[5] = make_vec(1'b0, rnd256(), {$urandom, $urandom}, {$urandom, $urandom}, rnd512(), 1);

    rst_n             = 1'b0;
    bus.in_valid      = 1'b1;
    bus.encryp_decryp = 1'b0;
    bus.in_key        = skey;
    bus.in_nonce      = 64'd1;
    bus.in_counter    = 64'd2;
    bus.in_data       = sdata;
    bus.m_axis_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("rst_valid", {63'd0, bus.m_axis_valid}, 64'd0);
      check("rst_data", bus.m_axis_data, 64'd0);
      check("rst_last", {63'd0, bus.m_axis_last}, 64'd0);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < 6; i++) send_and_check(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      vec_t rv;
      rv = make_vec(1'($urandom_range(0, 1)), rnd256(), {$urandom, $urandom},
                    {$urandom, $urandom}, rnd512(), 2);
      send_and_check(rv, $sformatf("rnd%0d", i));
    end

    back_to_back(vecs[1], make_vec(1'b1, skey, 64'd0, 64'd0, rnd512(), 0));

    // Mid-packet reset after five header beats, then a clean decryption packet.
    bus.m_axis_ready  = 1'b1;
    bus.encryp_decryp = 1'b0; bus.in_key = skey; bus.in_nonce = 64'h1; bus.in_counter = 64'h2;
    bus.in_data       = sdata; bus.in_valid = 1'b1;
    wait_ready(ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    w5 = skey[95:64];
    check("mrst_word5", bus.m_axis_data, w5);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_valid", {63'd0, bus.m_axis_valid}, 64'd0);
    check("mrst_data", bus.m_axis_data, 64'd0);
    check("mrst_last", {63'd0, bus.m_axis_last}, 64'd0);
    check("mrst_busy", {63'd0, bus.busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_and_check(vecs[1], "mrst_dec");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
